// File: rtl/mii_sdr_tx_out_pkg.sv
// Shared types and constants for the MII SDR transmit output path.
package mii_sdr_tx_out_pkg;

  localparam int MII_NIBBLE_W            = 4;
  localparam int MII_IFG_NIBBLES_DEFAULT = 24;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_LOW_ENC   = 3'd1;
  localparam logic [2:0] ST_HIGH_ENC  = 3'd2;
  localparam logic [2:0] ST_ABORT_ENC = 3'd3;
  localparam logic [2:0] ST_IFG_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOW   = ST_LOW_ENC,
    ST_HIGH  = ST_HIGH_ENC,
    ST_ABORT = ST_ABORT_ENC,
    ST_IFG   = ST_IFG_ENC
  } tx_state_e;

  // Bit order matches the pin register: {mii_tx_er, mii_tx_en, mii_txd}.
  typedef struct packed {
    logic                    tx_er;
    logic                    tx_en;
    logic [MII_NIBBLE_W-1:0] txd;
  } mii_pins_t;

  localparam mii_pins_t UNDERRUN_PINS = '{tx_er: 1'b1, tx_en: 1'b1, txd: '0};

  function automatic mii_pins_t data_pins(input logic [MII_NIBBLE_W-1:0] nib,
                                          input logic                    er);
    return '{tx_er: er, tx_en: 1'b1, txd: nib};
  endfunction

endpackage

// File: rtl/mii_sdr_tx_out_if.sv
// Byte-wide frame stream from the MAC into the MII transmit serialiser.
interface mii_sdr_tx_out_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_user;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, output s_user,
                  input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, input  s_user,
                  output s_ready);
endinterface

// File: rtl/ssio_sdr_out.sv
// Generic single-data-rate output register meant to be packed into the I/O block.
module ssio_sdr_out #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* IOB = "TRUE" *) logic [WIDTH-1:0] q_reg;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) q_reg <= '0;
    else     q_reg <= d;
  end

  assign q = q_reg;

endmodule

// File: rtl/mii_sdr_tx_out.sv
// MII transmit serialiser: byte stream in, low-then-high nibble pairs out, with
// inter-frame gap enforcement and mid-frame underrun abort.
module mii_sdr_tx_out
  import mii_sdr_tx_out_pkg::*;
#(
  parameter int IFG_NIBBLES = MII_IFG_NIBBLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  mii_sdr_tx_out_if.slave         stream,
  output logic [MII_NIBBLE_W-1:0] mii_txd,
  output logic                    mii_tx_en,
  output logic                    mii_tx_er,
  output logic                    underrun,
  output logic                    busy
);

  localparam int              CNT_W    = $clog2(IFG_NIBBLES + 1);
  localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(IFG_NIBBLES - 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic             underrun_q, underrun_d;
  logic             armed_q;
  logic             accept;
  logic             load_byte;
  mii_pins_t        pins_d, pins_q;

  // armed_q holds s_ready low for the first cycle after reset is released.
  assign stream.s_ready = armed_q &&
                          ((state_q == ST_IDLE) || (state_q == ST_ABORT) ||
                           ((state_q == ST_HIGH) && !last_q));
  assign accept = stream.s_valid && stream.s_ready;

  // The state names what the pin register shows this cycle, so pins_d is derived
  // from the transition being taken, giving one cycle from accept to pins.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d    = state_q;
    byte_d     = byte_q;
    last_d     = last_q;
    err_d      = err_q;
    ifg_cnt_d  = ifg_cnt_q;
    underrun_d = 1'b0;
    load_byte  = 1'b0;
    pins_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) load_byte = 1'b1;
      end
      ST_LOW: begin
        state_d = ST_HIGH;
        pins_d  = data_pins(byte_q[7:4], err_q);
      end
      ST_HIGH: begin
        if (last_q) begin
          state_d   = ST_IFG;
          ifg_cnt_d = IFG_LOAD;
        end else if (accept) begin
          load_byte = 1'b1;
        end else begin
          state_d    = ST_ABORT;
          underrun_d = 1'b1;
          pins_d     = UNDERRUN_PINS;
        end
      end
      ST_ABORT: begin
        if (accept && stream.s_last) begin
          state_d   = ST_IFG;
          ifg_cnt_d = IFG_LOAD;
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == '0) state_d   = ST_IDLE;
        else                 ifg_cnt_d = ifg_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // s_user only matters on the final byte of a frame.
    if (load_byte) begin
      state_d = ST_LOW;
      byte_d  = stream.s_data;
      last_d  = stream.s_last;
      err_d   = stream.s_last && stream.s_user;
      pins_d  = data_pins(stream.s_data[3:0], stream.s_last && stream.s_user);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ifg_cnt_q  <= '0;
      underrun_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ifg_cnt_q  <= ifg_cnt_d;
      underrun_q <= underrun_d;
      armed_q    <= 1'b1;
    end
  end

  // NOTE: the byte holding registers carry no reset; they are only read in
  // LOW/HIGH, which are reachable solely through a load.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    last_q <= last_d;
    err_q  <= err_d;
  end

  ssio_sdr_out #(
    .WIDTH(6)
  ) u_pins (
    .clk (clk),
    .rst (rst),
    .d   (pins_d),
    .q   (pins_q)
  );

  assign mii_txd   = pins_q.txd;
  assign mii_tx_en = pins_q.tx_en;
  assign mii_tx_er = pins_q.tx_er;
  assign underrun  = underrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mii_sdr_tx_out.sv
// Self-checking bench for mii_sdr_tx_out: directed cycle-exact cases plus a random
// frame mix checked against a nibble-stream reference model.
module tb_mii_sdr_tx_out;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [3:0] txd;
    logic       rdy;
    logic       busy;
    logic       ur;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mii_sdr_tx_out_if s0();
  mii_sdr_tx_out_if s1();

  logic [3:0] txd0, txd1;
  logic       en0, er0, ur0, busy0;
  logic       en1, er1, ur1, busy1;

  mii_sdr_tx_out #(.IFG_NIBBLES(24)) dut (
    .clk(clk), .rst(rst), .stream(s0),
    .mii_txd(txd0), .mii_tx_en(en0), .mii_tx_er(er0), .underrun(ur0), .busy(busy0)
  );

  mii_sdr_tx_out #(.IFG_NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .stream(s1),
    .mii_txd(txd1), .mii_tx_en(en1), .mii_tx_er(er1), .underrun(ur1), .busy(busy1)
  );

  smp_t tr0[$];
  smp_t tr1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    tr0.push_back({en0, er0, txd0, s0.s_ready, busy0, ur0});
    tr1.push_back({en1, er1, txd1, s1.s_ready, busy1, ur1});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pin(input smp_t s);
    return {s.en, s.er, s.txd};
  endfunction

  task automatic idle0();
    s0.s_valid = 1'b0; s0.s_last = 1'b0; s0.s_user = 1'b0; s0.s_data = 8'h00;
  endtask

  task automatic idle1();
    s1.s_valid = 1'b0; s1.s_last = 1'b0; s1.s_user = 1'b0; s1.s_data = 8'h00;
  endtask

  // Offers bytes as fast as s_ready allows; optional s_valid bubble before byte gap_at.
  task automatic send0(input logic [7:0] b[$], input logic user,
                       input int gap_at, input int gap_len);
    int w;
    for (int i = 0; i < b.size(); i++) begin
      if (i == gap_at && gap_len > 0) begin
        s0.s_valid = 1'b0;
        repeat (gap_len) tick();
      end
      s0.s_valid = 1'b1;
      s0.s_data  = b[i];
      s0.s_last  = (i == b.size() - 1);
      s0.s_user  = user;
      w = 0;
      while (s0.s_ready !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      if (w == 100) begin
        check("ready_timeout", 32'd0, 32'd1);
        idle0();
        return;
      end
      tick();
    end
    idle0();
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    logic [5:0] exp_nib[6];
    logic       exp_rdy[7];
    int         cnt, cnt2, nur, min_gap, last_en, w;
    int         len, gap_at, gap_len;
    logic       user;
    int         en_idx[$];

    idle0();
    idle1();

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_txd",     txd0,        0);
    check("rst_tx_en",   en0,         0);
    check("rst_tx_er",   er0,         0);
    check("rst_underrun", ur0,        0);
    check("rst_busy",    busy0,       0);
    check("rst_ready",   s0.s_ready,  0);
    rst = 1'b0;
    check("rst_release_ready_low", s0.s_ready, 0);
    tick();
    check("rst_release_ready_high", s0.s_ready, 1);

    // Single-byte frame 0xA5
    tr0.delete();
    bq = '{8'hA5};
    send0(bq, 1'b0, -1, 0);
    repeat (30) tick();
    check("t1_ready_c0", tr0[0].rdy, 1);
    check("t1_nib_lo", pin(tr0[1]), {1'b1, 1'b0, 4'h5});
    check("t1_nib_hi", pin(tr0[2]), {1'b1, 1'b0, 4'hA});
    cnt = 0; cnt2 = 0;
    for (int i = 0; i <= 30; i++) if (tr0[i].en) cnt++;
    for (int i = 1; i <= 26; i++) if (!tr0[i].rdy) cnt2++;
    check("t1_en_cycles", cnt, 2);
    check("t1_ready_low_1_26", cnt2, 26);
    check("t1_busy_c26", tr0[26].busy, 1);
    check("t1_ready_c27", tr0[27].rdy, 1);
    check("t1_busy_c27", tr0[27].busy, 0);

    // Back-to-back 3-byte frame
    tr0.delete();
    bq = '{8'h12, 8'h34, 8'h56};
    send0(bq, 1'b0, -1, 0);
    repeat (30) tick();
    exp_nib = '{6'h22, 6'h21, 6'h24, 6'h23, 6'h26, 6'h25};
    exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) check($sformatf("t2_nib%0d", i), pin(tr0[i+1]), exp_nib[i]);
    for (int i = 0; i < 7; i++) check($sformatf("t2_ready_c%0d", i), tr0[i].rdy, exp_rdy[i]);
    check("t2_en_after", tr0[7].en, 0);

    // Underrun: 0x12, 5 idle cycles, then 0xFF, 0xEE(last)
    tr0.delete();
    bq = '{8'h12, 8'hFF, 8'hEE};
    send0(bq, 1'b0, 1, 5);
    repeat (40) tick();
    check("t3_nib_lo", pin(tr0[1]), {1'b1, 1'b0, 4'h2});
    check("t3_nib_hi", pin(tr0[2]), {1'b1, 1'b0, 4'h1});
    check("t3_err_nib", pin(tr0[3]), {1'b1, 1'b1, 4'h0});
    check("t3_underrun_pulse", tr0[3].ur, 1);
    check("t3_abort_ready", tr0[3].rdy, 1);
    cnt = 0; cnt2 = 0; w = 0;
    foreach (tr0[i]) begin
      if (tr0[i].ur) cnt++;
      if (tr0[i].en) cnt2++;
      if (tr0[i].busy && !tr0[i].en && !tr0[i].rdy) w++;
    end
    check("t3_underrun_count", cnt, 1);
    check("t3_en_cycles", cnt2, 3);
    check("t3_ifg_cycles", w, 24);
    check("t3_ready_c31", tr0[31].rdy, 0);
    check("t3_ready_c32", tr0[32].rdy, 1);

    // Error flag on last byte; s_user also high on the first byte, which must be ignored
    tr0.delete();
    bq = '{8'hAB, 8'hCD};
    send0(bq, 1'b1, -1, 0);
    repeat (30) tick();
    check("t4_nib_B", pin(tr0[1]), {1'b1, 1'b0, 4'hB});
    check("t4_nib_A", pin(tr0[2]), {1'b1, 1'b0, 4'hA});
    check("t4_nib_D", pin(tr0[3]), {1'b1, 1'b1, 4'hD});
    check("t4_nib_C", pin(tr0[4]), {1'b1, 1'b1, 4'hC});

    // Reset during the low nibble of byte 2 of a 4-byte frame
    tr0.delete();
    s0.s_valid = 1'b1; s0.s_data = 8'h11; s0.s_last = 1'b0;
    tick();
    s0.s_data = 8'h22;
    tick();
    tick();
    s0.s_data = 8'h33;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle0();
    repeat (6) tick();
    check("t5_low_nib_byte2", pin(tr0[3]), {1'b1, 1'b0, 4'h2});
    check("t5_all_zero", tr0[4], 9'd0);
    check("t5_ready_after", tr0[5].rdy, 1);
    check("t5_busy_after", tr0[5].busy, 0);

    // IFG_NIBBLES=1: two single-byte frames offered back to back
    tr1.delete();
    s1.s_valid = 1'b1; s1.s_data = 8'h5A; s1.s_last = 1'b1;
    tick();
    s1.s_data = 8'hC3;
    w = 0;
    while (s1.s_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("t6_ready_wait", w < 50, 1);
    tick();
    idle1();
    repeat (10) tick();
    foreach (tr1[i]) if (tr1[i].en) en_idx.push_back(i);
    check("t6_en_count", en_idx.size(), 4);
    if (en_idx.size() == 4) begin
      check("t6_nib0", pin(tr1[en_idx[0]]), {1'b1, 1'b0, 4'hA});
      check("t6_nib3", pin(tr1[en_idx[3]]), {1'b1, 1'b0, 4'hC});
      check("t6_frame_gap", en_idx[2] - en_idx[1], 3);
      cnt = 0;
      for (int i = en_idx[1] + 1; i < en_idx[2]; i++) if (tr1[i].busy) cnt++;
      check("t6_ifg_cycles", cnt, 1);
    end

    // Random frame mix on the IFG=24 instance
    tr0.delete();
    exp_q.delete();
    nur = 0;
    for (int f = 0; f < 10; f++) begin
      len  = $urandom_range(1, 6);
      user = 1'($urandom_range(0, 1));
      bq.delete();
      for (int j = 0; j < len; j++) bq.push_back(8'($urandom));
      gap_at = -1; gap_len = 0;
      if (len >= 2 && $urandom_range(0, 2) == 0) begin
        gap_at  = $urandom_range(1, len - 1);
        gap_len = $urandom_range(1, 4);
      end
      if (gap_len >= 2) begin
        for (int j = 0; j < gap_at; j++) begin
          exp_q.push_back({1'b0, bq[j][3:0]});
          exp_q.push_back({1'b0, bq[j][7:4]});
        end
        exp_q.push_back(5'b1_0000);
        nur++;
      end else begin
        for (int j = 0; j < len; j++) begin
          exp_q.push_back({user && (j == len - 1), bq[j][3:0]});
          exp_q.push_back({user && (j == len - 1), bq[j][7:4]});
        end
      end
      send0(bq, user, gap_at, gap_len);
    end
    repeat (40) tick();

    obs_q.delete();
    cnt = 0; min_gap = 1000; last_en = -1;
    foreach (tr0[i]) begin
      if (tr0[i].ur) cnt++;
      if (tr0[i].en) begin
        obs_q.push_back({tr0[i].er, tr0[i].txd});
        if (last_en >= 0 && (i - last_en - 1) > 0 && (i - last_en - 1) < min_gap)
          min_gap = i - last_en - 1;
        last_en = i;
      end
    end
    check("rand_nibble_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("rand_nib%0d", i), obs_q[i], exp_q[i]);
    check("rand_underrun_count", cnt, nur);
    check("rand_min_gap_ge_25", min_gap >= 25, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
